// File: rtl/insn_buffer_if.sv
// Fetch-to-decode handshake bundle for insn_buffer: N-lane enqueue group in,
// N-lane head group out. Entry lanes are packed lane 0 in the low bits.
interface insn_buffer_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ENTRY_W = 129;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic [N-1:0]         in_valid;
  logic [N*ENTRY_W-1:0] in_entries;
  logic                 in_ready;
  logic [CNT_W-1:0]     free_count;
  logic                 out_ready;
  logic [N-1:0]         out_valid;
  logic [N*ENTRY_W-1:0] out_entries;

  // Fetch/decode side
  modport master (
    output in_valid, in_entries, out_ready,
    input  in_ready, free_count, out_valid, out_entries
  );

  // Buffer side
  modport slave (
    input  in_valid, in_entries, out_ready,
    output in_ready, free_count, out_valid, out_entries
  );
endinterface

// File: rtl/insn_buffer.sv
// Superscalar instruction buffer: circular FIFO taking up to N fetched
// instructions per cycle and presenting up to N in program order to decode.
// Optional same-cycle empty-buffer bypass is enabled by defining IB_BYPASS_EN.
module insn_buffer #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          squash_i,
  insn_buffer_if.slave  ib
);

  localparam int unsigned ENTRY_W = 129;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        predict_taken;
    logic [31:0] predict_target;
  } ib_entry_t;

  ib_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CNT_W-1:0]   free_c;
  logic               in_ready_c;
  logic               byp_c;
  logic               run_c;
  logic [N-1:0]       lead_mask_c;
  logic [CNT_W-1:0]   enq_cnt_c;
  logic [CNT_W-1:0]   deq_cnt_c;
  ib_entry_t          in_lane_c [N];
  logic [N-1:0]       wr_en_c;
  logic [PTR_W-1:0]   wr_idx_c [N];
  logic [N-1:0]       out_valid_c;
  logic [N*ENTRY_W-1:0] out_entries_c;

  // Space check is purely a function of registered occupancy
  always_comb begin
    free_c     = CNT_W'(DEPTH) - count_q;
    in_ready_c = (free_c >= CNT_W'(N));
  end

  assign ib.free_count = free_c;
  assign ib.in_ready   = in_ready_c;

`ifdef IB_BYPASS_EN
  // Empty buffer with a consuming decoder hands the fetch group straight through
  assign byp_c = (count_q == '0) && in_ready_c && ib.out_ready && !squash_i && !reset_i;
`else
  assign byp_c = 1'b0;
`endif

  // Lanes behind the first invalid lane are dropped to keep program order contiguous
  always_comb begin
    lead_mask_c = '0;
    run_c       = 1'b1;
    for (int i = 0; i < N; i++) begin
      run_c          = run_c & ib.in_valid[i];
      lead_mask_c[i] = run_c;
    end
  end

  always_comb begin
    enq_cnt_c = '0;
    for (int i = 0; i < N; i++) begin
      enq_cnt_c = enq_cnt_c + CNT_W'(lead_mask_c[i]);
    end
    if (!in_ready_c || byp_c) begin
      enq_cnt_c = '0;
    end
  end

  always_comb begin
    deq_cnt_c = '0;
    if (ib.out_ready) begin
      deq_cnt_c = (count_q < CNT_W'(N)) ? count_q : CNT_W'(N);
    end
  end

  // Pointers wrap for free because DEPTH is a power of two
  always_comb begin
    head_d  = head_q + PTR_W'(deq_cnt_c);
    tail_d  = tail_q + PTR_W'(enq_cnt_c);
    count_d = count_q + enq_cnt_c - deq_cnt_c;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || squash_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_lane_c[i] = ib_entry_t'(ib.in_entries[i*ENTRY_W +: ENTRY_W]);
      wr_en_c[i]   = (CNT_W'(i) < enq_cnt_c) && !reset_i && !squash_i;
      wr_idx_c[i]  = tail_q + PTR_W'(i);
    end
  end

  // Storage is not reset; readout is gated by occupancy
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < N; i++) begin
      if (wr_en_c[i]) begin
        mem_q[wr_idx_c[i]] <= in_lane_c[i];
      end
    end
  end

  always_comb begin
    out_valid_c   = '0;
    out_entries_c = '0;
    for (int i = 0; i < N; i++) begin
      if (count_q > CNT_W'(i)) begin
        out_valid_c[i]                        = 1'b1;
        out_entries_c[i*ENTRY_W +: ENTRY_W]   = mem_q[head_q + PTR_W'(i)];
      end
    end
    if (byp_c) begin
      out_valid_c = lead_mask_c;
      for (int i = 0; i < N; i++) begin
        if (lead_mask_c[i]) begin
          out_entries_c[i*ENTRY_W +: ENTRY_W] = ib.in_entries[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  assign ib.out_valid   = out_valid_c;
  assign ib.out_entries = out_entries_c;

  a_count_bound: assert property (@(posedge clock_i) disable iff (reset_i)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: doc/insn_buffer.md
INSN_BUFFER -- requirements
Module: insn_buffer

Interface
REQ-001 Parameter N, default `N: superscalar width, in lanes.
REQ-002 Parameter DEPTH, default 8: entry count; SHALL be a power of two and >= N.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 squash  input  1  flush request from the out-of-order core (ROB mispredict).
REQ-006 in_valid  input  N  fetch lanes valid; lane 0 oldest.
REQ-007 in_entries  input  N x IB_ENTRY  per lane {inst[31:0], PC[31:0], NPC[31:0], predict_taken, predict_target[31:0]}.
REQ-008 in_ready  output  1  buffer can accept a full N-wide group this cycle.
REQ-009 free_count  output  $clog2(DEPTH+1)  free slots at cycle start.
REQ-010 out_ready  input  1  decode/dispatch can consume; driven as !structural_hazard of the core.
REQ-011 out_valid  output  N  head lanes valid; lane 0 oldest.
REQ-012 out_entries  output  N x IB_ENTRY  head entries in program order.

Function
REQ-013 Circular FIFO with head pointer, tail pointer ($clog2(DEPTH) bits each, wrapping modulo DEPTH) and count (0..DEPTH).
REQ-014 free_count = DEPTH - count; in_ready = (free_count >= N); both registered-state based and independent of same-cycle dequeue.
REQ-015 Enqueue count k = number of leading ones of in_valid from lane 0; lanes after the first 0 SHALL be dropped; k = 0 when !in_ready.
REQ-016 Enqueued lane i is written at tail+i; tail advances by k.
REQ-017 out_valid[i] = (count > i); out_entries[i] = entry at head+i when out_valid[i], else all zero.
REQ-018 Dequeue count d = min(count, N) when out_ready, else 0; head advances by d; partial groups (d < N) SHALL be allowed.
REQ-019 Next count = count + k - d; simultaneous enqueue and dequeue in one cycle SHALL be supported, including at full and at empty.
REQ-020 Enqueue-to-out_valid latency is 1 cycle; program order is preserved across pointer wrap-around.
REQ-021 squash SHALL clear head, tail and count in the same edge; same-cycle enqueue and dequeue are discarded; squash has priority over both.
REQ-022 Overflow and underflow are impossible by construction; count SHALL never exceed DEPTH.

Reset
REQ-023 On reset: head = 0, tail = 0, count = 0, so out_valid = 0, out_entries = 0, free_count = DEPTH, in_ready = 1.
REQ-024 Reset mid-operation SHALL discard all entries identically to squash; reset has priority over squash, enqueue and dequeue.
REQ-025 Storage array contents need not be reset; outputs are gated by out_valid.

Configuration
REQ-026 Macro IB_BYPASS_EN.
REQ-027 When IB_BYPASS_EN is defined and count = 0, in_ready = 1 and out_ready = 1: out_valid = leading-ones mask of in_valid and out_entries = in_entries in the same cycle (combinational); these entries SHALL NOT be stored; count stays 0.
REQ-028 Under REQ-027, if out_ready = 0 the entries are enqueued normally; squash in the same cycle still forces out_valid = 0.
REQ-029 When IB_BYPASS_EN is undefined, no combinational path from in_* to out_* SHALL exist; latency is always 1 cycle.

Verification (N=2, DEPTH=8, bypass off unless stated)
REQ-030 Reset, out_ready = 0, in_valid = 11 for 4 cycles with PCs 0x0..0x1C -> free_count 8,6,4,2,0; in_ready = 0 at free_count 0; out_entries PCs = 0x0, 0x4.
REQ-031 in_valid = 10 (lane 0 invalid) -> nothing enqueued, count unchanged; in_valid = 01 from empty -> next cycle out_valid = 01, free_count = 7.
REQ-032 Fill to 8, drain 6 (3 cycles, out_ready = 1), enqueue 4 more with PCs 0x20..0x2C -> pointers wrap; dequeued PC order 0x18, 0x1C, 0x20, 0x24, 0x28, 0x2C.
REQ-033 count = 4, squash = 1 with in_valid = 11 and out_ready = 1 -> next cycle count = 0, out_valid = 00, free_count = 8.
REQ-034 count = 1, out_ready = 1, in_valid = 11 -> out_valid = 01 this cycle; next cycle count = 2, order preserved.
REQ-035 IB_BYPASS_EN defined, empty, out_ready = 1, in_valid = 11 PC 0x40/0x44 -> same-cycle out_valid = 11 with PCs 0x40/0x44; next cycle count = 0.
